coffee_order_frontend: RTL

//  Upstream order/payment stage for the coffee machine controller. Accepts coins and a drink

---
 rtl/coffee_order_frontend.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/coffee_order_frontend.sv
// coffee_order_frontend
//   Order/payment front end for the coffee machine controller. Collects coins, prices a drink
//   selection, and drives start_btn/mode_select. The request is held until the machine reports
//   brew_done, and any remaining credit is then returned as change.
//
//   Mode encoding: 0 milk+sugar, 1 milk, 2 espresso+sugar, 3 espresso, 4 cappuccino+sugar,
//   5 cappuccino. Even modes carry the sugar surcharge.
//
//   Optional feature macro: ORDER_TIMEOUT_EN
//     defined   - an inactivity counter refunds credit after TIMEOUT_CYC idle cycles in COLLECT
//     undefined - COLLECT waits indefinitely
//
// Ports
//   clk            in   clock, rising edge
//   rst            in   synchronous active-high reset
//   coin_valid     in   one-cycle coin strobe
//   coin_value     in   coin denomination (legal 1, 2, 5, 10)
//   sel_valid      in   one-cycle drink selection strobe
//   sel_mode       in   requested mode 0..5
//   cancel         in   one-cycle cancel/refund request
//   brew_done      in   machine done pulse
//   start_btn      out  start request to the machine (level)
//   mode_select    out  latched mode, stable while start_btn is high
//   credit         out  current credit
//   coin_reject    out  pulse: coin not accepted
//   err_bad_sel    out  pulse: sel_mode > 5
//   err_low_credit out  pulse: credit below price
//   change_valid   out  pulse: change_amount valid
//   change_amount  out  last refund/change value, held until the next one
//   busy           out  high in BREW or CHANGE
module coffee_order_frontend #(
    parameter int unsigned CREDIT_W    = 8,
    parameter int unsigned MAX_CREDIT  = 200,
    parameter int unsigned PRICE_MILK  = 15,
    parameter int unsigned PRICE_ESP   = 20,
    parameter int unsigned PRICE_CAP   = 25,
    parameter int unsigned SUGAR_ADD   = 2,
    parameter int unsigned TIMEOUT_CYC = 1000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                coin_valid,
    input  logic [3:0]          coin_value,
    input  logic                sel_valid,
    input  logic [2:0]          sel_mode,
    input  logic                cancel,
    input  logic                brew_done,
    output logic                start_btn,
    output logic [2:0]          mode_select,
    output logic [CREDIT_W-1:0] credit,
    output logic                coin_reject,
    output logic                err_bad_sel,
    output logic                err_low_credit,
    output logic                change_valid,
    output logic [CREDIT_W-1:0] change_amount,
    output logic                busy
);

    // Elaboration-time parameter sanity checks.
    if (MAX_CREDIT >= (1 << CREDIT_W)) begin : g_bad_max_credit
        $error("MAX_CREDIT does not fit in CREDIT_W bits");
    end
    if (TIMEOUT_CYC == 0) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 1");
    end

    typedef enum logic [1:0] {StIdle, StCollect, StBrew, StChange} state_e;

    localparam logic [CREDIT_W:0]   MAX_C        = (CREDIT_W + 1)'(MAX_CREDIT);
    localparam logic [CREDIT_W-1:0] PRICE_MILK_C = CREDIT_W'(PRICE_MILK);
    localparam logic [CREDIT_W-1:0] PRICE_ESP_C  = CREDIT_W'(PRICE_ESP);
    localparam logic [CREDIT_W-1:0] PRICE_CAP_C  = CREDIT_W'(PRICE_CAP);
    localparam logic [CREDIT_W-1:0] SUGAR_C      = CREDIT_W'(SUGAR_ADD);

    state_e              state;
    logic                coin_legal;
    logic                coin_ok;
    logic [CREDIT_W:0]   coin_sum;    // one extra bit so the ceiling check sees overflow
    logic [CREDIT_W-1:0] credit_add;  // credit after any accepted same-cycle coin
    logic [CREDIT_W-1:0] price;
    logic                sel_bad;
    logic                sel_afford;
    logic                timeout;

    always_comb begin
        case (coin_value)
            4'd1, 4'd2, 4'd5, 4'd10: coin_legal = 1'b1;
            default:                 coin_legal = 1'b0;
        endcase
        coin_sum   = {1'b0, credit} + (CREDIT_W + 1)'(coin_value);
        coin_ok    = coin_valid && coin_legal && (coin_sum <= MAX_C);
        credit_add = coin_ok ? coin_sum[CREDIT_W-1:0] : credit;

        case (sel_mode[2:1])
            2'd1:    price = PRICE_ESP_C;
            2'd2:    price = PRICE_CAP_C;
            default: price = PRICE_MILK_C;
        endcase
        if (!sel_mode[0]) begin
            price = price + SUGAR_C;
        end
        sel_bad    = sel_mode > 3'd5;
        // Selection is priced against the credit before any same-cycle coin.
        sel_afford = credit >= price;
    end

`ifdef ORDER_TIMEOUT_EN
    localparam int unsigned          TIMEOUT_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(TIMEOUT_CYC - 1);

    logic [TIMEOUT_W-1:0] idle_cnt;

    always_ff @(posedge clk) begin
        if (rst || (state != StCollect) || coin_valid || sel_valid) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + TIMEOUT_W'(1);
        end
    end

    // Fires on the TIMEOUT_CYC-th consecutive strobe-free cycle in COLLECT.
    assign timeout = (state == StCollect) && !coin_valid && !sel_valid &&
                     (idle_cnt == TIMEOUT_LAST);
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= StIdle;
            start_btn      <= 1'b0;
            mode_select    <= '0;
            credit         <= '0;
            coin_reject    <= 1'b0;
            err_bad_sel    <= 1'b0;
            err_low_credit <= 1'b0;
            change_valid   <= 1'b0;
            change_amount  <= '0;
            busy           <= 1'b0;
        end else begin
            coin_reject    <= 1'b0;
            err_bad_sel    <= 1'b0;
            err_low_credit <= 1'b0;
            change_valid   <= 1'b0;

            case (state)
                StIdle, StCollect: begin
                    coin_reject <= coin_valid && !coin_ok;
                    if (cancel && (state == StCollect)) begin
                        // Cancel beats a same-cycle selection; a same-cycle coin is refunded too.
                        change_valid  <= 1'b1;
                        change_amount <= credit_add;
                        credit        <= '0;
                        busy          <= 1'b1;
                        state         <= StChange;
                    end else if (sel_valid && sel_bad) begin
                        err_bad_sel <= 1'b1;
                        credit      <= credit_add;
                        state       <= (credit_add != '0) ? StCollect : StIdle;
                    end else if (sel_valid && !sel_afford) begin
                        err_low_credit <= 1'b1;
                        credit         <= credit_add;
                        state          <= (credit_add != '0) ? StCollect : StIdle;
                    end else if (sel_valid) begin
                        mode_select <= sel_mode;
                        credit      <= credit_add - price;
                        start_btn   <= 1'b1;
                        busy        <= 1'b1;
                        state       <= StBrew;
                    end else if (timeout) begin
                        change_valid  <= 1'b1;
                        change_amount <= credit;
                        credit        <= '0;
                        busy          <= 1'b1;
                        state         <= StChange;
                    end else begin
                        credit <= credit_add;
                        state  <= (credit_add != '0) ? StCollect : StIdle;
                    end
                end

                StBrew: begin
                    coin_reject <= coin_valid;
                    if (brew_done) begin
                        start_btn <= 1'b0;
                        if (credit != '0) begin
                            change_valid  <= 1'b1;
                            change_amount <= credit;
                            credit        <= '0;
                            state         <= StChange;
                        end else begin
                            busy  <= 1'b0;
                            state <= StIdle;
                        end
                    end
                end

                StChange: begin
                    // Change pulse was issued on entry; this cycle only drains back to idle.
                    coin_reject <= coin_valid;
                    busy        <= 1'b0;
                    state       <= StIdle;
                end

                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule
